mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of Avalon masters (range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8); BE_W = DATA_W/8.
REQ-004 SHALL have ports `clk  in  1  clock`, then `reset  in  1  reset, synchronous, active-high`.
REQ-005 SHALL have ports `m_address  in  N_MASTERS x ADDR_W` and `m_read, m_write  in  N_MASTERS`: per-master requests.
REQ-006 SHALL have ports `m_writedata  in  N_MASTERS x DATA_W` and `m_byteenable  in  N_MASTERS x BE_W`.
REQ-007 SHALL have ports `m_waitrequest  out  N_MASTERS` and `m_readdata  out  DATA_W` (broadcast to all masters).
REQ-008 SHALL have ports `s_address  out  ADDR_W`, `s_read, s_write  out  1`, `s_writedata  out  DATA_W`, `s_byteenable  out  BE_W`.
REQ-009 SHALL have ports `s_waitrequest  in  1` and `s_readdata  in  DATA_W`.
REQ-010 SHALL have ports `grant_valid  out  1  grant held` and `grant_idx  out  clog2(N_MASTERS)  granted master`.

Function
REQ-011 SHALL implement states IDLE and BUSY.
REQ-012 IDLE: any master with m_read|m_write high SHALL be selected, grant_idx registered, next state BUSY; no requester -> stay IDLE.
REQ-013 IDLE: s_read=s_write=0, s_byteenable=0, all m_waitrequest=1.
REQ-014 BUSY: s_* outputs SHALL equal the granted master's signals combinationally; m_waitrequest[grant]=s_waitrequest; all others =1.
REQ-015 BUSY: transfer completes in the cycle (m_read|m_write)[grant]=1 and s_waitrequest=0; next state IDLE.
REQ-016 Minimum latency SHALL be request cycle + 1 arbitration cycle + 1 slave cycle; back-to-back transfers from one master SHALL incur one IDLE bubble.
REQ-017 Granted master dropping read and write in BUSY (protocol violation) SHALL return to IDLE next cycle with no transfer issued.
REQ-018 m_read and m_write both high on one master SHALL be treated as a write; s_read is forced to 0.
REQ-019 m_readdata SHALL equal s_readdata at all times; it is valid only for the granted master on completion.
REQ-020 grant_valid SHALL be 1 iff state is BUSY.

Reset
REQ-021 reset SHALL force IDLE, grant_valid=0, grant_idx=0, rr pointer=N_MASTERS-1, all m_waitrequest=1, s_read=s_write=0.
REQ-022 reset asserted mid-transfer SHALL abandon the transfer; s_read and s_write are 0 from the next cycle.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined, selection SHALL start at (last granted index + 1) mod N_MASTERS and wrap; the pointer updates on each completion only.
REQ-024 Without ARB_ROUND_ROBIN_EN, selection SHALL be fixed priority, lowest index wins, and there is no pointer register.

Structure
REQ-025 arb_state_t (IDLE, BUSY) SHALL live in the shared definitions package with the other CPU state typedefs.
REQ-026 Selection logic SHALL be the sub-module mips_bus_arb_picker (inputs: request vector, start index; outputs: valid, index).

Verification
REQ-027 Single master 0 read at 0xBFC00000, s_waitrequest=0 -> s_read high one cycle after request; m_waitrequest[0] low in that cycle; m_readdata=s_readdata.
REQ-028 Masters 0 and 1 request simultaneously with round robin -> grants 0 then 1; without the macro and master 0 requesting continuously -> grants 0 every time.
REQ-029 Slave holds s_waitrequest=1 for 3 cycles on a write of 0xDEADBEEF with byteenable 4'b0011 -> s_* outputs stable for 4 cycles; master 1 m_waitrequest=1 throughout.
REQ-030 N_MASTERS=4, all requesting, round robin -> grant order 0,1,2,3,0 (wrap-around).
REQ-031 Reset asserted in BUSY mid-wait -> next cycle IDLE, s_write=0, grant_valid=0.
REQ-032 Read and write both high on master 0 -> s_write=1, s_read=0.

Source files
------------

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared CPU bus definitions: arbiter FSM states and decoded bus operation.
package mips_bus_arbiter_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } bus_op_t;

    // A master raising read and write together is serviced as a write.
    function automatic bus_op_t bus_op(input logic rd, input logic wr);
        if (wr)      return OP_WRITE;
        else if (rd) return OP_READ;
        else         return OP_NONE;
    endfunction

endpackage

// File: rtl/mips_bus_arb_picker.sv
// Request selector: first requester found scanning upward from start, wrapping.
module mips_bus_arb_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(start) + i) % N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// N-master to one-slave Avalon-MM arbiter with an IDLE/BUSY grant FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module mips_bus_arbiter
    import mips_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int IW        = $clog2(N_MASTERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0] m_address,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS-1:0]             m_write,
    input  logic [N_MASTERS-1:0][DATA_W-1:0] m_writedata,
    input  logic [N_MASTERS-1:0][BE_W-1:0]   m_byteenable,
    output logic [N_MASTERS-1:0]             m_waitrequest,
    output logic [DATA_W-1:0]                m_readdata,
    output logic [ADDR_W-1:0]                s_address,
    output logic                             s_read,
    output logic                             s_write,
    output logic [DATA_W-1:0]                s_writedata,
    output logic [BE_W-1:0]                  s_byteenable,
    input  logic                             s_waitrequest,
    input  logic [DATA_W-1:0]                s_readdata,
    output logic                             grant_valid,
    output logic [IW-1:0]                    grant_idx
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] pick_start;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    bus_op_t       gnt_op;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign pick_start = IW'((int'(ptr_q) + 1) % N_MASTERS);
`else
    assign pick_start = '0;
`endif

    mips_bus_arb_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
        .req   (m_read | m_write),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign m_readdata  = s_readdata;
    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = grant_q;
    assign gnt_op      = bus_op(m_read[grant_q], m_write[grant_q]);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif
        s_address     = '0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        m_waitrequest = '1;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_address     = m_address[grant_q];
                s_writedata   = m_writedata[grant_q];
                s_byteenable  = m_byteenable[grant_q];
                s_read        = (gnt_op == OP_READ);
                s_write       = (gnt_op == OP_WRITE);
                m_waitrequest[grant_q] = s_waitrequest;
                // A master that abandons its request releases the bus without a transfer.
                if (gnt_op == OP_NONE) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= IW'(N_MASTERS - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a 2-master and a 4-master instance.
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 2-master instance
    logic [1:0][31:0] m_address, m_writedata;
    logic [1:0]       m_read, m_write, m_waitrequest;
    logic [1:0][3:0]  m_byteenable;
    logic [31:0]      m_readdata, s_address, s_writedata, s_readdata;
    logic             s_read, s_write, s_waitrequest, grant_valid;
    logic [3:0]       s_byteenable;
    logic [0:0]       grant_idx;

    // 4-master instance
    logic [3:0][31:0] m4_address, m4_writedata;
    logic [3:0]       m4_read, m4_write, m4_waitrequest;
    logic [3:0][3:0]  m4_byteenable;
    logic [31:0]      m4_readdata, s4_address, s4_writedata, s4_readdata;
    logic             s4_read, s4_write, s4_waitrequest, grant4_valid;
    logic [3:0]       s4_byteenable;
    logic [1:0]       grant4_idx;

    mips_bus_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    mips_bus_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut4 (
        .clk(clk), .reset(reset),
        .m_address(m4_address), .m_read(m4_read), .m_write(m4_write),
        .m_writedata(m4_writedata), .m_byteenable(m4_byteenable),
        .m_waitrequest(m4_waitrequest), .m_readdata(m4_readdata),
        .s_address(s4_address), .s_read(s4_read), .s_write(s4_write),
        .s_writedata(s4_writedata), .s_byteenable(s4_byteenable),
        .s_waitrequest(s4_waitrequest), .s_readdata(s4_readdata),
        .grant_valid(grant4_valid), .grant_idx(grant4_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got %0b want 0", grant_valid); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL rst_grant_idx got %0d want 0", grant_idx); end
        checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL rst_waitreq got %b want 11", m_waitrequest); end
        checks++; if ({s_read, s_write} !== 2'b00) begin errors++; $display("FAIL rst_rdwr got %b want 00", {s_read, s_write}); end
        checks++; if (s_byteenable !== 4'h0) begin errors++; $display("FAIL rst_be got %h want 0", s_byteenable); end
        checks++; if (m4_waitrequest !== 4'hF) begin errors++; $display("FAIL rst4_waitreq got %b want 1111", m4_waitrequest); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        m_read[0]      = 1'b1;
        m_address[0]   = 32'hBFC0_0000;
        s_waitrequest  = 1'b0;
        s_readdata     = 32'h1234_5678;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rd_req_cycle_sread got %0b want 0", s_read); end
        checks++; if (m_readdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_readdata_idle got %h want 12345678", m_readdata); end
        step();
        #1;
        checks++; if (s_read !== 1'b1 || s_write !== 1'b0) begin errors++; $display("FAIL rd_sread got %b want 10", {s_read, s_write}); end
        checks++; if (s_address !== 32'hBFC0_0000) begin errors++; $display("FAIL rd_addr got %h want bfc00000", s_address); end
        checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL rd_waitreq got %b want 10", m_waitrequest); end
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin errors++; $display("FAIL rd_grant got %0b/%0d want 1/0", grant_valid, grant_idx); end
        checks++; if (m_readdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_readdata got %h want 12345678", m_readdata); end
        step();
        m_read[0] = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0 || s_read !== 1'b0) begin errors++; $display("FAIL rd_done got %0b/%0b want 0/0", grant_valid, s_read); end
    endtask

    task automatic test_two_masters();
        int exp_g[3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_read        = 2'b11;
        s_waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            checks++; if (grant_valid !== 1'b1 || int'(grant_idx) != exp_g[k]) begin errors++; $display("FAIL arb_grant%0d got %0b/%0d want 1/%0d", k, grant_valid, grant_idx, exp_g[k]); end
            step();
            #1;
            checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL arb_bubble%0d got %0b want 0", k, grant_valid); end
        end
        m_read = 2'b00;
    endtask

    task automatic test_wait_write();
        logic [68:0] exp_s;
        m_write[0]      = 1'b1;
        m_address[0]    = 32'h0000_1000;
        m_writedata[0]  = 32'hDEAD_BEEF;
        m_byteenable[0] = 4'b0011;
        s_waitrequest   = 1'b1;
        exp_s = {1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011};
        step();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) s_waitrequest = 1'b0;
            #1;
            checks++; if ({s_write, s_address, s_writedata, s_byteenable} !== exp_s) begin errors++; $display("FAIL wr_stable%0d got %h want %h", c, {s_write, s_address, s_writedata, s_byteenable}, exp_s); end
            checks++; if (m_waitrequest !== ((c == 3) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL wr_waitreq%0d got %b want %b", c, m_waitrequest, (c == 3) ? 2'b10 : 2'b11); end
            if (c < 3) step();
        end
        step();
        m_write[0] = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL wr_done got %0b/%0b want 0/0", grant_valid, s_write); end
    endtask

    task automatic test_violation();
        m_read[1]     = 1'b1;
        m_address[1]  = 32'h0000_2000;
        s_waitrequest = 1'b1;
        step();
        #1;
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1 || s_read !== 1'b1) begin errors++; $display("FAIL viol_grant got %0b/%0d/%0b want 1/1/1", grant_valid, grant_idx, s_read); end
        m_read[1] = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL viol_drop got %0b want 0", s_read); end
        step();
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL viol_idle got %0b want 0", grant_valid); end
    endtask

    task automatic test_reset_mid();
        m_write[0]    = 1'b1;
        s_waitrequest = 1'b1;
        step();
        #1;
        checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0b want 1", s_write); end
        reset = 1'b1;
        step();
        #1;
        checks++; if (s_write !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL rmid_abandon got %0b/%0b want 0/0", s_write, grant_valid); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL rmid_idx got %0d want 0", grant_idx); end
        m_write[0] = 1'b0;
        reset      = 1'b0;
        step();
    endtask

    task automatic test_rw_both();
        m_read[0]     = 1'b1;
        m_write[0]    = 1'b1;
        s_waitrequest = 1'b0;
        step();
        #1;
        checks++; if ({s_write, s_read} !== 2'b10) begin errors++; $display("FAIL rw_both got %b want 10", {s_write, s_read}); end
        step();
        m_read[0]  = 1'b0;
        m_write[0] = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rw_done got %0b want 0", grant_valid); end
    endtask

    task automatic test_four_wrap();
        int exp_g[5];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        m4_read = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            checks++; if (grant4_valid !== 1'b1 || int'(grant4_idx) != exp_g[k]) begin errors++; $display("FAIL wrap_grant%0d got %0b/%0d want 1/%0d", k, grant4_valid, grant4_idx, exp_g[k]); end
            checks++; if (s4_read !== 1'b1) begin errors++; $display("FAIL wrap_sread%0d got %0b want 1", k, s4_read); end
            step();
        end
        m4_read = 4'h0;
    endtask

    initial begin
        reset          = 1'b1;
        m_address      = '0; m_writedata  = '0; m_byteenable  = '0;
        m_read         = '0; m_write      = '0;
        s_waitrequest  = 1'b0; s_readdata = '0;
        m4_address     = '0; m4_writedata = '0; m4_byteenable = '0;
        m4_read        = '0; m4_write     = '0;
        s4_waitrequest = 1'b0; s4_readdata = 32'h0;
        test_reset();
        test_single_read();
        test_two_masters();
        test_wait_write();
        test_violation();
        test_reset_mid();
        test_rw_both();
        test_four_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
